// File: rtl/accel_pkg.sv
// accel_pkg: shared types and default widths for the MAC stream reader.
//   mac_state_t  - reader FSM state encoding (IDLE / ACCUM / DONE)
//   DEF_*        - default operand, accumulator and term-count widths
package accel_pkg;

    localparam int unsigned DEF_SIZE     = 8;
    localparam int unsigned DEF_ACC_SIZE = 24;
    localparam int unsigned DEF_CNT_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_t;

endpackage

// File: rtl/mac_unit.sv
// mac_unit: signed multiply-accumulate register.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   clear       - zero the accumulator (wins over enable)
//   enable      - add sext(a*w) into the accumulator this edge
//   a, w        - signed SIZE-bit operands
//   acc         - ACC_SIZE-bit accumulator, wraps modulo 2^ACC_SIZE
module mac_unit
    import accel_pkg::*;
#(
    parameter int unsigned SIZE     = DEF_SIZE,
    parameter int unsigned ACC_SIZE = DEF_ACC_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    input  logic [SIZE-1:0]     a,
    input  logic [SIZE-1:0]     w,
    output logic [ACC_SIZE-1:0] acc
);

    localparam int unsigned PROD_SIZE = 2 * SIZE;

    logic signed [PROD_SIZE-1:0] product;
    logic signed [ACC_SIZE-1:0]  term;

    // Operands are sign-extended to the product width before multiplying,
    // so the low PROD_SIZE bits are the exact signed product.
    assign product = PROD_SIZE'($signed(a)) * PROD_SIZE'($signed(w));
    assign term    = ACC_SIZE'(product);

    // Accumulator register; plain modular add, no saturation.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + $unsigned(term);
        end
    end

endmodule

// File: rtl/mac_stream_reader.sv
// mac_stream_reader: pulls paired activation/weight words from two Fifos and
// accumulates their signed dot product over `length` terms.
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   start, length         - begin a dot product of `length` terms (IDLE only)
//   a_data, a_empty       - activation Fifo head word and empty flag
//   a_read_update         - activation Fifo pop strobe
//   w_data, w_empty       - weight Fifo head word and empty flag
//   w_read_update         - weight Fifo pop strobe
//   result, result_valid  - dot-product result, held until accepted
//   result_ready          - downstream accepts result
//   busy                  - state is not IDLE
// Build option: define RELU_EN to clamp negative results to zero.
module mac_stream_reader
    import accel_pkg::*;
#(
    parameter int unsigned SIZE     = DEF_SIZE,
    parameter int unsigned ACC_SIZE = DEF_ACC_SIZE,
    parameter int unsigned CNT_SIZE = DEF_CNT_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CNT_SIZE-1:0] length,
    input  logic [SIZE-1:0]     a_data,
    input  logic                a_empty,
    output logic                a_read_update,
    input  logic [SIZE-1:0]     w_data,
    input  logic                w_empty,
    output logic                w_read_update,
    output logic [ACC_SIZE-1:0] result,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                busy
);

    if (ACC_SIZE < 2 * SIZE) begin : g_bad_acc_size
        $error("mac_stream_reader: ACC_SIZE must be at least 2*SIZE");
    end

    mac_state_t          state;
    mac_state_t          next_state;
    logic [CNT_SIZE-1:0] remaining;
    logic [ACC_SIZE-1:0] acc;
    logic                pop;
    logic                accept_start;

    // Both Fifos pop together, and only when each has a word ready.
    assign pop          = (state == ACCUM) && !a_empty && !w_empty;
    assign accept_start = (state == IDLE) && start;

    assign a_read_update = pop;
    assign w_read_update = pop;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (length == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (pop && (remaining == CNT_SIZE'(1))) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Terms still to be consumed; a zero-length start loads zero harmlessly.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= '0;
        end else if (accept_start) begin
            remaining <= length;
        end else if (pop) begin
            remaining <= remaining - CNT_SIZE'(1);
        end
    end

    mac_unit #(
        .SIZE     (SIZE),
        .ACC_SIZE (ACC_SIZE)
    ) u_mac_unit (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept_start),
        .enable (pop),
        .a      (a_data),
        .w      (w_data),
        .acc    (acc)
    );

`ifdef RELU_EN
    // Negative sums clamp to zero.
    assign result = acc[ACC_SIZE-1] ? '0 : acc;
`else
    assign result = acc;
`endif

    assign result_valid = (state == DONE);
    assign busy         = (state != IDLE);

endmodule
